rgb_led_arbiter: RTL and testbench
==================================

RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 2000000, number of clk cycles one grant owns the LED (legal range >=1).
REQ-002 SHALL have parameter GAP_CYCLES, default 200000, number of LED-off clk cycles after each grant (legal range >=0).
REQ-003 SHALL have port clk, input, 1, 12 MHz system clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req, input, 3, per-requester LED request, level-held.
REQ-006 SHALL have ports color0/color1/color2, input, 3 each, requested colour: bit2=R, bit1=G, bit0=B, 1=lit.
REQ-007 SHALL have port gnt, output, 3, one-hot grant, registered.
REQ-008 SHALL have port done, output, 3, one-cycle pulse on the granted bit when the hold completes normally.
REQ-009 SHALL have port busy, output, 1, high in HOLD or GAP.
REQ-010 SHALL have ports RGB_R, RGB_G, RGB_B, output, 1 each, active-low LED drives, registered.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD and GAP.
REQ-012 In IDLE with any req bit high, SHALL select the first asserted requester starting at round-robin pointer ptr and wrapping 2->0; enter HOLD next cycle.
REQ-013 On the IDLE->HOLD transition SHALL latch the selected requester's colour input in that same cycle; later colour changes are ignored until the next grant.
REQ-014 In HOLD, gnt SHALL equal the one-hot granted index and RGB_x SHALL equal the inverted latched colour bits.
REQ-015 gnt SHALL stay high for exactly HOLD_CYCLES cycles unless released early per REQ-018.
REQ-016 done[i] SHALL pulse high in the last cycle of gnt[i] on normal completion only.
REQ-017 On leaving HOLD, ptr SHALL become (granted index + 1) mod 3; then enter GAP, or enter IDLE when GAP_CYCLES=0.
REQ-018 Early release: if req of the granted requester is low in any HOLD cycle, that cycle SHALL be treated as the last HOLD cycle; done SHALL NOT pulse; ptr still advances.
REQ-019 In GAP, gnt=0 and RGB_R/G/B=1 (off) for exactly GAP_CYCLES cycles, then IDLE.
REQ-020 In IDLE, gnt=0, done=0, busy=0, LED off.
REQ-021 Requests arriving during HOLD or GAP SHALL be arbitrated only in the next IDLE cycle; earliest back-to-back grant start spacing is HOLD_CYCLES+GAP_CYCLES+1 cycles.
REQ-022 A single shared down-counter SHALL be sized to hold max(HOLD_CYCLES, GAP_CYCLES) with no wrap-around; it is reloaded on each state entry.
REQ-023 A requester with req low in IDLE SHALL never be granted; req with colour 3'b000 SHALL still be granted (LED stays dark).

Reset
REQ-024 With reset high at a clk edge, SHALL go to IDLE, ptr=0, counter=0, gnt=0, done=0, busy=0, RGB_R=RGB_G=RGB_B=1.
REQ-025 Reset asserted mid-HOLD or mid-GAP SHALL abort immediately with no done pulse; first arbitration occurs in the first cycle after reset deasserts.

Verification (HOLD_CYCLES=4, GAP_CYCLES=2)
REQ-026 req=3'b001, color0=3'b100 -> gnt=001 for 4 cycles, RGB_R=0/G=1/B=1, done[0] in 4th cycle, 2 off cycles, IDLE, regrant 7 cycles after first grant.
REQ-027 req=3'b111 held -> grant order 0,1,2,0 with starts 7 cycles apart; never two gnt bits high.
REQ-028 Requester 1 granted, req[1] drops in 2nd HOLD cycle -> gnt[1] low next cycle, no done, GAP 2 cycles, ptr=2.
REQ-029 color0 changed 3'b100->3'b010 mid-HOLD -> LED stays red until hold ends.
REQ-030 reset pulsed in 3rd HOLD cycle -> next cycle all outputs at reset values, next grant goes to lowest asserted index from ptr=0.
REQ-031 GAP_CYCLES=0 build, req=3'b011 -> grant 0 then grant 1 starting 5 cycles later, LED never off between grants except the IDLE cycle.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter that gives one of three requesters timed ownership of an RGB LED.
// After a grant ends, the LED stays dark for a guard gap before the next arbitration.
module rgb_led_arbiter #(
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [2:0] color0,
    input  logic [2:0] color1,
    input  logic [2:0] color2,
    output logic [2:0] gnt,
    output logic [2:0] done,
    output logic       busy,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_gnt;
    logic [2:0]       r_rgb;

    logic [1:0]       w_cand_idx [3];
    logic [2:0]       w_cand_req;
    logic [1:0]       w_sel;
    logic [2:0]       w_sel_color;
    logic             w_any_req;
    logic             w_req_gnt;
    logic             w_cnt_zero;
    logic             w_hold_last;
    logic [1:0]       w_next_ptr;

    // Candidate gi is the requester gi positions after the pointer, wrapping 2->0.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] w_sum;
            assign w_sum          = {1'b0, r_ptr} + 3'(gi);
            assign w_cand_idx[gi] = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            assign w_cand_req[gi] = req[w_cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_sel = w_cand_idx[2];
        if (w_cand_req[0]) begin
            w_sel = w_cand_idx[0];
        end else if (w_cand_req[1]) begin
            w_sel = w_cand_idx[1];
        end
    end

    always_comb begin
        w_sel_color = color2;
        case (w_sel)
            2'd0:    w_sel_color = color0;
            2'd1:    w_sel_color = color1;
            default: w_sel_color = color2;
        endcase
    end

    assign w_any_req   = |req;
    assign w_req_gnt   = req[r_idx];
    assign w_cnt_zero  = (r_cnt == '0);
    // A dropped request ends the hold in the current cycle, like a natural timeout.
    assign w_hold_last = w_cnt_zero | ~w_req_gnt;
    assign w_next_ptr  = (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
            r_gnt   <= 3'b000;
            r_rgb   <= 3'b111;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_HOLD;
                        r_idx   <= w_sel;
                        r_cnt   <= HOLD_LOAD;
                        r_gnt   <= 3'b001 << w_sel;
                        r_rgb   <= ~w_sel_color;
                    end
                end
                S_HOLD: begin
                    if (w_hold_last) begin
                        r_ptr <= w_next_ptr;
                        r_gnt <= 3'b000;
                        r_rgb <= 3'b111;
                        if (GAP_CYCLES > 0) begin
                            r_state <= S_GAP;
                            r_cnt   <= GAP_LOAD;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_gnt   <= 3'b000;
                    r_rgb   <= 3'b111;
                end
            endcase
        end
    end

    // done follows the live request so a drop in the final hold cycle suppresses it.
    assign done  = (r_state == S_HOLD && w_cnt_zero && w_req_gnt && !reset) ? r_gnt : 3'b000;
    assign busy  = (r_state != S_IDLE);
    assign gnt   = r_gnt;
    assign RGB_R = r_rgb[2];
    assign RGB_G = r_rgb[1];
    assign RGB_B = r_rgb[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Randomized bench for rgb_led_arbiter: two builds (gap 2 and gap 0) driven by the same
// inputs and compared each cycle against an ownership/gap model of the arbitration rules.
module tb_rgb_led_arbiter;

    localparam int H      = 4;
    localparam int G_A    = 2;
    localparam int G_B    = 0;
    localparam int NCYC   = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] color0, color1, color2;

    logic [2:0] gnt_a, done_a, gnt_b, done_b;
    logic       busy_a, busy_b;
    logic       r_a, g_a, b_a, r_b, g_b, b_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         owner;     // -1 when nobody holds the LED
        int         held;      // hold cycles elapsed including the current one
        int         gap_left;  // dark cycles still to come
        int         ptr;
        logic [2:0] color;
    } mstate_t;

    mstate_t ma, mb;

    rgb_led_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G_A)) dut_a (
        .clk(clk), .reset(reset), .req(req),
        .color0(color0), .color1(color1), .color2(color2),
        .gnt(gnt_a), .done(done_a), .busy(busy_a),
        .RGB_R(r_a), .RGB_G(g_a), .RGB_B(b_a)
    );

    rgb_led_arbiter #(.HOLD_CYCLES(H), .GAP_CYCLES(G_B)) dut_b (
        .clk(clk), .reset(reset), .req(req),
        .color0(color0), .color1(color1), .color2(color2),
        .gnt(gnt_b), .done(done_b), .busy(busy_b),
        .RGB_R(r_b), .RGB_G(g_b), .RGB_B(b_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic mstate_t model_reset();
        mstate_t s;
        s.owner    = -1;
        s.held     = 0;
        s.gap_left = 0;
        s.ptr      = 0;
        s.color    = 3'b000;
        return s;
    endfunction

    function automatic mstate_t model_step(mstate_t s, int gap, logic rst, logic [2:0] rq,
                                           logic [8:0] cols);
        mstate_t n = s;
        if (rst) begin
            n = model_reset();
        end else if (s.owner >= 0) begin
            if (s.held == H || !rq[s.owner]) begin
                n.ptr      = (s.owner + 1) % 3;
                n.owner    = -1;
                n.gap_left = gap;
            end else begin
                n.held = s.held + 1;
            end
        end else if (s.gap_left > 0) begin
            n.gap_left = s.gap_left - 1;
        end else if (rq != 3'b000) begin
            for (int k = 2; k >= 0; k--) begin
                int c;
                c = (s.ptr + k) % 3;
                if (rq[c]) n.owner = c;
            end
            n.held  = 1;
            n.color = cols[n.owner*3 +: 3];
        end
        return n;
    endfunction

    task automatic check_dut(input string nm, input mstate_t s, input logic [2:0] g,
                             input logic [2:0] d, input logic bsy, input logic [2:0] rgb);
        logic [2:0] eg, ed, ergb;
        logic       eb;
        eg   = (s.owner >= 0) ? (3'b001 << s.owner) : 3'b000;
        eb   = (s.owner >= 0) || (s.gap_left > 0);
        ergb = (s.owner >= 0) ? ~s.color : 3'b111;
        ed   = 3'b000;
        if (s.owner >= 0 && s.held == H && !reset) begin
            if (req[s.owner]) ed = eg;
        end
        check_eq({nm, "_gnt"},  32'(g),   32'(eg));
        check_eq({nm, "_done"}, 32'(d),   32'(ed));
        check_eq({nm, "_busy"}, 32'(bsy), 32'(eb));
        check_eq({nm, "_rgb"},  32'(rgb), 32'(ergb));
    endtask

    initial begin
        reset  = 1'b1;
        req    = 3'b000;
        color0 = 3'b100;
        color1 = 3'b010;
        color2 = 3'b001;
        ma     = model_reset();
        mb     = model_reset();
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            cyc = n;
            if (n < 3) begin
                reset = 1'b1;
            end else if (n < 45) begin
                reset = 1'b0;
                req   = 3'b111;
                if ($urandom_range(0, 1) == 0) color0 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) color1 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) color2 = 3'($urandom_range(0, 7));
            end else begin
                reset = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) color0 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) color1 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) color2 = 3'($urandom_range(0, 7));
            end
            #1;
            if (n > 0) begin
                check_dut("a", ma, gnt_a, done_a, busy_a, {r_a, g_a, b_a});
                check_dut("b", mb, gnt_b, done_b, busy_b, {r_b, g_b, b_b});
            end
            ma = model_step(ma, G_A, reset, req, {color2, color1, color0});
            mb = model_step(mb, G_B, reset, req, {color2, color1, color0});
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
